// File: rtl/knn_engine.sv
// knn_engine: streaming k-nearest-neighbour search. Squared distances from a captured test point
// feed an ascending K-entry list that is replayed on a valid/ready result stream.
module knn_engine #(
    parameter int DATA_W = 16,
    parameter int N_DIM  = 2,
    parameter int K      = 4,
    parameter int ID_W   = 8,
    localparam int DIST_W = 2*DATA_W + 2 + $clog2(N_DIM)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_DIM*DATA_W-1:0] test_pt,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_DIM*DATA_W-1:0] in_data,
    input  logic [ID_W-1:0]         in_id,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic [DIST_W-1:0]       out_dist,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int SQ_W  = 2*DATA_W + 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUTPUT} state_t;

    state_t                    state, state_nxt;
    logic [N_DIM*DATA_W-1:0]   test_q;

    logic                      s1_valid;
    logic signed [DATA_W:0]    s1_diff  [N_DIM];
    logic signed [DATA_W:0]    diff_nxt [N_DIM];
    logic [ID_W-1:0]           s1_id;

    logic                      s2_valid;
    logic [DIST_W-1:0]         s2_dist;
    logic [ID_W-1:0]           s2_id;
    logic signed [SQ_W-1:0]    sq [N_DIM];
    logic [DIST_W-1:0]         sq_sum;

    logic [DIST_W-1:0]         list_dist [K];
    logic [ID_W-1:0]           list_id   [K];
    logic [DIST_W-1:0]         nxt_dist  [K];
    logic [ID_W-1:0]           nxt_id    [K];
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          idx;
    logic [CNT_W-1:0]          ins_pos;

    logic                      accept;
    logic                      start_ok;
    logic                      insert;
    logic                      out_fire;
    logic                      done_q;

    assign in_ready  = (state == STREAM);
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUTPUT);
    assign out_last  = out_valid && (idx == count - CNT_W'(1));
    assign accept    = in_valid && in_ready;
    assign start_ok  = start && (state == IDLE);
    assign out_fire  = out_valid && out_ready;
    assign insert    = s2_valid && (ins_pos < CNT_W'(K));
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // DRAIN exits once stage 1 is empty: the final point is in stage 2 and lands in the list on that edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (accept && in_last) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid) state_nxt = OUTPUT;
            OUTPUT:  if (out_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int d = 0; d < N_DIM; d++) begin
            diff_nxt[d] = {in_data[d*DATA_W + DATA_W - 1], in_data[d*DATA_W +: DATA_W]}
                        - {test_q[d*DATA_W + DATA_W - 1], test_q[d*DATA_W +: DATA_W]};
        end
    end

    always_comb begin
        sq_sum = '0;
        for (int d = 0; d < N_DIM; d++) begin
            sq[d]  = SQ_W'(s1_diff[d]) * SQ_W'(s1_diff[d]);
            sq_sum = sq_sum + DIST_W'($unsigned(sq[d]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            test_q   <= '0;
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_dist  <= '0;
            s2_id    <= '0;
            for (int d = 0; d < N_DIM; d++) s1_diff[d] <= '0;
        end else begin
            if (start_ok) test_q <= test_pt;
            s1_valid <= accept;
            s1_id    <= in_id;
            s1_diff  <= diff_nxt;
            s2_valid <= s1_valid;
            s2_dist  <= sq_sum;
            s2_id    <= s1_id;
        end
    end

    // Insertion slot sits after every stored entry whose dist is <= the new one, so ties keep arrival order.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((CNT_W'(i) < count) && (list_dist[i] <= s2_dist)) ins_pos = ins_pos + CNT_W'(1);
        end
    end

    always_comb begin
        nxt_dist[0] = (ins_pos == '0) ? s2_dist : list_dist[0];
        nxt_id[0]   = (ins_pos == '0) ? s2_id   : list_id[0];
        for (int i = 1; i < K; i++) begin
            if (CNT_W'(i) < ins_pos) begin
                nxt_dist[i] = list_dist[i];
                nxt_id[i]   = list_id[i];
            end else if (CNT_W'(i) == ins_pos) begin
                nxt_dist[i] = s2_dist;
                nxt_id[i]   = s2_id;
            end else begin
                nxt_dist[i] = list_dist[i-1];
                nxt_id[i]   = list_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            for (int i = 0; i < K; i++) begin
                list_dist[i] <= '0;
                list_id[i]   <= '0;
            end
        end else if (start_ok) begin
            count <= '0;
            for (int i = 0; i < K; i++) begin
                list_dist[i] <= '0;
                list_id[i]   <= '0;
            end
        end else if (insert) begin
            list_dist <= nxt_dist;
            list_id   <= nxt_id;
            if (count < CNT_W'(K)) count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= out_fire && out_last;
            if (start_ok)                 idx <= '0;
            else if (out_fire && out_last) idx <= '0;
            else if (out_fire)            idx <= idx + CNT_W'(1);
        end
    end

    always_comb begin
        out_id   = '0;
        out_dist = '0;
        if (state == OUTPUT) begin
            for (int i = 0; i < K; i++) begin
                if (CNT_W'(i) == idx) begin
                    out_id   = list_id[i];
                    out_dist = list_dist[i];
                end
            end
        end
    end

endmodule
